// File: rtl/ins_queue_mw.sv
// Instruction queue with 2-wide push, 2-wide pop and show-ahead front outputs.
// Rejected pushes and illegal pops are dropped and latch a sticky overflow flag.
module ins_queue_mw #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned INS_W = 32,
   parameter int unsigned PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ready,
   input  logic                       clear,
   input  logic [1:0]                 push_cnt,
   input  logic [INS_W-1:0]           push_ins0,
   input  logic [INS_W-1:0]           push_ins1,
   input  logic [PC_W-1:0]            push_pc0,
   input  logic [PC_W-1:0]            push_pc1,
   input  logic [PC_W-1:0]            push_pred_pc0,
   input  logic [PC_W-1:0]            push_pred_pc1,
   input  logic [1:0]                 pop_cnt,
   output logic [1:0]                 front_valid,
   output logic [INS_W-1:0]           front_ins0,
   output logic [INS_W-1:0]           front_ins1,
   output logic [PC_W-1:0]            front_pc0,
   output logic [PC_W-1:0]            front_pc1,
   output logic [PC_W-1:0]            front_pred_pc0,
   output logic [PC_W-1:0]            front_pred_pc1,
   output logic [$clog2(DEPTH):0]     free_cnt,
   output logic                       full,
   output logic                       overflow
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW-1:0]    head_p1, tail_p1;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CW-1:0]    free_w, push_amt, pop_amt;
   logic             push_ok, pop_ok, do_op;

   logic [INS_W-1:0] ins_mem  [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [PC_W-1:0]  pred_mem [DEPTH];

   assign head_p1  = head_q + AW'(1);
   assign tail_p1  = tail_q + AW'(1);
   assign free_w   = CW'(DEPTH) - count_q;
   // Acceptance is judged on start-of-cycle occupancy; same-cycle pops give no credit.
   assign push_ok  = (push_cnt != 2'd3) && (CW'(push_cnt) <= free_w);
   assign pop_ok   = (pop_cnt != 2'd3) && (CW'(pop_cnt) <= count_q);
   assign push_amt = push_ok ? CW'(push_cnt) : '0;
   assign pop_amt  = pop_ok ? CW'(pop_cnt) : '0;
   assign do_op    = ready && !clear;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (ready) begin
         head_d     = head_q + (pop_ok ? AW'(pop_cnt) : '0);
         tail_d     = tail_q + (push_ok ? AW'(push_cnt) : '0);
         count_d    = count_q + push_amt - pop_amt;
         overflow_d = overflow_q | ~push_ok | ~pop_ok;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage carries no reset; validity comes solely from count.
   always_ff @(posedge clk) begin
      if (do_op && push_ok && (push_cnt != 2'd0)) begin
         ins_mem[tail_q]  <= push_ins0;
         pc_mem[tail_q]   <= push_pc0;
         pred_mem[tail_q] <= push_pred_pc0;
         if (push_cnt == 2'd2) begin
            ins_mem[tail_p1]  <= push_ins1;
            pc_mem[tail_p1]   <= push_pc1;
            pred_mem[tail_p1] <= push_pred_pc1;
         end
      end
   end

   always_comb begin
      front_valid    = {(count_q >= CW'(2)), (count_q >= CW'(1))};
      front_ins0     = ins_mem[head_q];
      front_pc0      = pc_mem[head_q];
      front_pred_pc0 = pred_mem[head_q];
      front_ins1     = ins_mem[head_p1];
      front_pc1      = pc_mem[head_p1];
      front_pred_pc1 = pred_mem[head_p1];
      free_cnt       = free_w;
      full           = (free_w < CW'(2));
      overflow       = overflow_q;
   end
endmodule

// File: tb/tb_ins_queue_mw.sv
// Randomized scoreboard bench for ins_queue_mw: the driver models occupancy with a queue,
// the monitor compares front entries and status each cycle on the falling edge.
module tb_ins_queue_mw;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ready = 1'b1;
   logic        clear = 1'b0;
   logic [1:0]  push_cnt = 2'd0;
   logic [1:0]  pop_cnt = 2'd0;
   logic [31:0] push_ins0 = '0, push_ins1 = '0, push_pc0 = '0, push_pc1 = '0;
   logic [31:0] push_pred_pc0 = '0, push_pred_pc1 = '0;
   logic [1:0]  front_valid;
   logic [31:0] front_ins0, front_ins1, front_pc0, front_pc1, front_pred_pc0, front_pred_pc1;
   logic [4:0]  free_cnt;
   logic        full, overflow;

   ins_queue_mw #(.DEPTH(DEPTH), .INS_W(32), .PC_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .ready(ready), .clear(clear),
      .push_cnt(push_cnt), .push_ins0(push_ins0), .push_ins1(push_ins1),
      .push_pc0(push_pc0), .push_pc1(push_pc1),
      .push_pred_pc0(push_pred_pc0), .push_pred_pc1(push_pred_pc1),
      .pop_cnt(pop_cnt), .front_valid(front_valid),
      .front_ins0(front_ins0), .front_ins1(front_ins1),
      .front_pc0(front_pc0), .front_pc1(front_pc1),
      .front_pred_pc0(front_pred_pc0), .front_pred_pc1(front_pred_pc1),
      .free_cnt(free_cnt), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   ent_t sb_q[$];
   int   exp_cnt = 0;
   int   exp_pop = 0;
   bit   exp_ovf = 0, exp_ovf_nxt = 0, pend_clear = 0;
   int   n_chk = 0, n_err = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare visible state against the model, then retire consumed entries.
   always @(negedge clk) begin
      chk("front_valid", 96'(front_valid), {94'd0, exp_cnt >= 2, exp_cnt >= 1});
      chk("free_cnt", 96'(free_cnt), 96'(DEPTH - exp_cnt));
      chk("full", 96'(full), 96'((DEPTH - exp_cnt) < 2));
      chk("overflow", 96'(overflow), 96'(exp_ovf));
      if (exp_cnt >= 1) chk("front0", {front_ins0, front_pc0, front_pred_pc0}, sb_q[0]);
      if (exp_cnt >= 2) chk("front1", {front_ins1, front_pc1, front_pred_pc1}, sb_q[1]);
      for (int i = 0; i < exp_pop; i++) void'(sb_q.pop_front());
   end

   task automatic step(input logic [1:0] pc, input logic [1:0] pp, input logic clr,
                       input logic rdy);
      int cnt;
      bit push_ok, pop_ok;
      ent_t e0, e1;
      @(posedge clk);
      if (pend_clear) sb_q.delete();
      pend_clear = 0;
      exp_ovf = exp_ovf_nxt;
      #1;
      cnt = sb_q.size();
      e0 = {$urandom, $urandom, $urandom};
      e1 = {$urandom, $urandom, $urandom};
      {push_ins0, push_pc0, push_pred_pc0} = e0;
      {push_ins1, push_pc1, push_pred_pc1} = e1;
      push_cnt = pc;
      pop_cnt = pp;
      clear = clr;
      ready = rdy;
      push_ok = (pc != 3) && (int'(pc) <= DEPTH - cnt);
      pop_ok = (pp != 3) && (int'(pp) <= cnt);
      exp_cnt = cnt;
      exp_pop = 0;
      if (clr) pend_clear = 1;
      else if (rdy) begin
         if (!push_ok || !pop_ok) exp_ovf_nxt = 1;
         if (pop_ok) exp_pop = pp;
         if (push_ok && pc >= 1) sb_q.push_back(e0);
         if (push_ok && pc == 2) sb_q.push_back(e1);
      end
   endtask

   // Asynchronous reset pulse away from any clock edge, checked before the next edge.
   task automatic mid_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_front_valid", 96'(front_valid), 96'd0);
      chk("rst_free_cnt", 96'(free_cnt), 96'(DEPTH));
      chk("rst_full", 96'(full), 96'd0);
      chk("rst_overflow", 96'(overflow), 96'd0);
      sb_q.delete();
      exp_cnt = 0; exp_pop = 0; exp_ovf = 0; exp_ovf_nxt = 0; pend_clear = 0;
      push_cnt = 2'd0; pop_cnt = 2'd0; clear = 1'b0; ready = 1'b1;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #1;
      chk("init_front_valid", 96'(front_valid), 96'd0);
      chk("init_free_cnt", 96'(free_cnt), 96'(DEPTH));
      chk("init_overflow", 96'(overflow), 96'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Two-wide push becomes visible next cycle
      step(2, 0, 0, 1);
      step(0, 0, 0, 1);
      // Fill to 15, rejected 2-wide push, then a 1-wide push to completely full
      for (int i = 0; i < 6; i++) step(2, 0, 0, 1);
      step(1, 0, 0, 1);
      step(2, 0, 0, 1);
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 2, 0, 1);
      mid_reset();

      // Pop at count 1 alongside a 2-wide push
      step(1, 0, 0, 1);
      step(2, 1, 0, 1);
      step(0, 0, 0, 1);
      // Interleaved streaming across multiple pointer wraps
      for (int i = 0; i < 20; i++) step(2, 2, 0, 1);
      step(0, 2, 0, 1);
      step(0, 0, 0, 1);

      // Clear wins over push; stall freezes everything
      step(2, 0, 0, 1);
      step(2, 0, 0, 1);
      step(1, 0, 0, 1);
      step(2, 0, 1, 1);
      step(0, 0, 0, 1);
      step(2, 0, 0, 1);
      step(2, 1, 0, 0);
      step(3, 3, 0, 0);
      step(0, 0, 0, 1);
      step(2, 0, 1, 0);
      step(0, 0, 0, 1);

      // Illegal pop then asynchronous reset clears the sticky flag
      step(1, 0, 0, 1);
      step(0, 2, 0, 1);
      step(0, 0, 0, 1);
      mid_reset();

      for (int i = 0; i < 600; i++) begin
         logic [1:0] pc, pp;
         pc = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         pp = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (i % 100 == 0) pp = 2'd0;
         step(pc, pp, $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);
         if (i == 300) mid_reset();
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/ins_queue_mw.md
INS_QUEUE_MW -- requirements
Module: ins_queue_mw

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the entry count; it is a power of two, at least 4.
REQ-002 Parameter INS_W, default 32, SHALL set the instruction width.
REQ-003 Parameter PC_W, default 32, SHALL set the PC and predicted-PC width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-006 Port ready, input, 1 bit, SHALL be the global stall; when 0, no state changes.
REQ-007 Port clear, input, 1 bit, SHALL be the synchronous flush (mispredict).
REQ-008 Port push_cnt, input, 2 bits, SHALL give the number of entries offered this cycle (0..2).
REQ-009 Ports push_ins0/1 (INS_W), push_pc0/1 (PC_W) and push_pred_pc0/1 (PC_W), all inputs, SHALL carry the entries; slot 0 is older.
REQ-010 Port pop_cnt, input, 2 bits, SHALL give the number of front entries consumed by decode this cycle (0..2).
REQ-011 Port front_valid, output, 2 bits, SHALL mark front_valid[0] as oldest entry present and front_valid[1] as second-oldest present.
REQ-012 Ports front_ins0/1, front_pc0/1 and front_pred_pc0/1, all outputs, SHALL carry the oldest and second-oldest entries.
REQ-013 Port free_cnt, output, clog2(DEPTH)+1 bits, SHALL give the free slots.
REQ-014 Port full, output, 1 bit, SHALL assert when free_cnt < 2, meaning a 2-wide push cannot be guaranteed.
REQ-015 Port overflow, output, 1 bit, SHALL be a sticky error flag for a rejected push or an illegal pop.

Function
REQ-016 State SHALL consist of head and tail pointers (clog2(DEPTH) bits, wrapping modulo DEPTH), count (clog2(DEPTH)+1 bits), the entry arrays and the overflow bit.
REQ-017 Front outputs SHALL be combinational show-ahead reads at head and head+1 mod DEPTH, so an entry is visible the cycle after its push edge.
REQ-018 front_valid[0] SHALL equal (count>=1) and front_valid[1] SHALL equal (count>=2); front data is don't-care where valid is 0.
REQ-019 free_cnt SHALL equal DEPTH-count, and full SHALL equal (free_cnt<2); both are combinational from registered state.
REQ-020 Priority SHALL be: reset_n low, then clear, then ready low (hold), then normal operation.
REQ-021 Clear SHALL set head=tail=count=0 regardless of push/pop that cycle, without altering overflow.
REQ-022 A push SHALL be accepted only if push_cnt <= free_cnt at the start of the cycle; same-cycle pops are not credited.
REQ-023 An accepted push SHALL write slot 0 at tail and slot 1 at tail+1 mod DEPTH, then advance tail by push_cnt mod DEPTH.
REQ-024 A rejected push SHALL be dropped entirely (no partial write, tail unchanged) and SHALL set overflow.
REQ-025 A pop SHALL be legal only if pop_cnt <= count and pop_cnt != 3; a legal pop advances head by pop_cnt mod DEPTH.
REQ-026 An illegal pop SHALL leave head unchanged and SHALL set overflow.
REQ-027 push_cnt=3 SHALL be treated as a rejected push.
REQ-028 Count SHALL update as count + accepted_push - legal_pop, with simultaneous push and pop in the same cycle allowed.
REQ-029 Pop at count=1 with push_cnt=2 SHALL leave count=2, and entries SHALL remain in order across pointer wrap.
REQ-030 Overflow SHALL clear only on reset.

Reset
REQ-031 Assertion of reset_n=0 SHALL immediately, without a clock, force head=0, tail=0, count=0 and overflow=0, giving front_valid=00, free_cnt=DEPTH, full=0 and overflow=0.
REQ-032 Entry arrays SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries.
REQ-034 Normal operation SHALL begin on the first rising clk after reset_n deasserts.

Verification
REQ-035 Scenario: DEPTH=16; after reset, push_cnt=2 with A,B, then pop_cnt=0 -> next cycle front_valid=11, front0=A, front1=B, free_cnt=14.
REQ-036 Scenario: fill to count=15, then push_cnt=2 -> push rejected, count stays 15, overflow=1, full=1; then push_cnt=1 -> count=16, free_cnt=0.
REQ-037 Scenario: count=1 holding A, push_cnt=2 with B,C and pop_cnt=1 -> count=2, front0=B, front1=C.
REQ-038 Scenario: stream 40 entries with 2-wide push and 2-wide pop interleaved -> pointers wrap twice, output order identical to input order, overflow=0.
REQ-039 Scenario: count=5, clear=1 with push_cnt=2 -> count=0, front_valid=00, free_cnt=16; ready=0 with push/pop active -> no state change.
REQ-040 Scenario: count=1, pop_cnt=2 -> head unchanged, overflow=1; then reset_n pulse low mid-cycle -> count=0 and overflow=0 before the next clk edge.
